// File: rtl/check_constant.sv
// Per-bit stuck-high / stuck-low detector with saturating run counters.
// Define CHECK_CONSTANT_SYNC_EN to add a 2-flop input synchronizer.
module check_constant #(
  parameter int unsigned THRESHOLD            = 32,
  parameter int unsigned WIDTH                = 2,
  parameter bit          CHECK_STABLE_HIGH_EN = 1'b1,
  parameter bit          CHECK_STABLE_LOW_EN  = 1'b1
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic [WIDTH-1:0] D_I,
  output logic [WIDTH-1:0] IS_ALWAYS_1_O,
  output logic [WIDTH-1:0] IS_ALWAYS_0_O
);

  localparam int unsigned CW = $clog2(THRESHOLD + 1);
  localparam logic [CW-1:0] C_MAX = CW'(THRESHOLD);
  localparam logic [CW-1:0] C_ARM = CW'(THRESHOLD - 1);
  localparam logic [CW-1:0] C_ONE = CW'(1);

  logic [WIDTH-1:0] w_s;
  logic             w_vld;

`ifdef CHECK_CONSTANT_SYNC_EN
  logic [WIDTH-1:0] r_sync1;
  logic [WIDTH-1:0] r_sync2;
  logic [1:0]       r_vld;

  // Synchronizer reset contents are not real samples; hold off counting.
  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_vld   <= '0;
    end else begin
      r_sync1 <= D_I;
      r_sync2 <= r_sync1;
      r_vld   <= {r_vld[0], 1'b1};
    end
  end

  assign w_s   = r_sync2;
  assign w_vld = r_vld[1];
`else
  assign w_s   = D_I;
  assign w_vld = 1'b1;
`endif

  for (genvar i = 0; i < int'(WIDTH); i++) begin : g_bit
    if (CHECK_STABLE_HIGH_EN) begin : g_hi
      logic [CW-1:0] r_hi_cnt;
      logic          r_hi;

      always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
          r_hi_cnt <= '0;
          r_hi     <= 1'b0;
        end else if (w_vld) begin
          if (w_s[i]) begin
            if (r_hi_cnt != C_MAX)
              r_hi_cnt <= r_hi_cnt + C_ONE;
          end else begin
            r_hi_cnt <= '0;
          end
          r_hi <= w_s[i] && (r_hi_cnt >= C_ARM);
        end
      end

      assign IS_ALWAYS_1_O[i] = r_hi;
    end else begin : g_no_hi
      assign IS_ALWAYS_1_O[i] = 1'b0;
    end

    if (CHECK_STABLE_LOW_EN) begin : g_lo
      logic [CW-1:0] r_lo_cnt;
      logic          r_lo;

      always_ff @(posedge CLK_I or negedge RST_I) begin
        if (!RST_I) begin
          r_lo_cnt <= '0;
          r_lo     <= 1'b0;
        end else if (w_vld) begin
          if (!w_s[i]) begin
            if (r_lo_cnt != C_MAX)
              r_lo_cnt <= r_lo_cnt + C_ONE;
          end else begin
            r_lo_cnt <= '0;
          end
          r_lo <= !w_s[i] && (r_lo_cnt >= C_ARM);
        end
      end

      assign IS_ALWAYS_0_O[i] = r_lo;
    end else begin : g_no_lo
      assign IS_ALWAYS_0_O[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_check_constant.sv
// Scoreboard bench for check_constant: run-length reference model,
// directed stability scenarios plus randomized hold lengths.
module tb_check_constant;

  localparam int TH = 32;
  localparam int W  = 2;

  logic         CLK_I = 1'b0;
  logic         RST_I = 1'b0;
  logic [W-1:0] D_I   = '0;
  logic [W-1:0] IS_ALWAYS_1_O;
  logic [W-1:0] IS_ALWAYS_0_O;

  check_constant #(
    .THRESHOLD           (TH),
    .WIDTH               (W),
    .CHECK_STABLE_HIGH_EN(1'b1),
    .CHECK_STABLE_LOW_EN (1'b1)
  ) dut (
    .CLK_I        (CLK_I),
    .RST_I        (RST_I),
    .D_I          (D_I),
    .IS_ALWAYS_1_O(IS_ALWAYS_1_O),
    .IS_ALWAYS_0_O(IS_ALWAYS_0_O)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct packed {
    logic [W-1:0] one;
    logic [W-1:0] zero;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  int           run [W];
  logic [W-1:0] lvl = '0;
`ifdef CHECK_CONSTANT_SYNC_EN
  logic [W-1:0] p0 = '0;
  logic [W-1:0] p1 = '0;
  int           vcnt = 0;
`endif

  // Model: length of the current run of equal samples per bit.
  task automatic step(input logic [W-1:0] d, input logic rst);
    exp_t         e;
    logic [W-1:0] s;
    bit           v;
    @(negedge CLK_I);
    RST_I = rst;
    D_I   = d;
    s = d;
    v = 1'b1;
`ifdef CHECK_CONSTANT_SYNC_EN
    if (!rst) begin
      p0 = '0;
      p1 = '0;
      vcnt = 0;
    end else begin
      s = p1;
      v = (vcnt >= 2);
      p1 = p0;
      p0 = d;
      vcnt++;
    end
`endif
    if (!rst) begin
      for (int i = 0; i < W; i++) run[i] = 0;
    end else if (v) begin
      for (int i = 0; i < W; i++) begin
        if (run[i] > 0 && lvl[i] == s[i]) begin
          run[i]++;
        end else begin
          run[i] = 1;
          lvl[i] = s[i];
        end
      end
    end
    e = '0;
    for (int i = 0; i < W; i++) begin
      if (run[i] >= TH) begin
        if (lvl[i]) e.one[i] = 1'b1;
        else        e.zero[i] = 1'b1;
      end
    end
    q.push_back(e);
    @(posedge CLK_I);
  endtask

  task automatic hold(input logic [W-1:0] d, input int n);
    for (int k = 0; k < n; k++) step(d, 1'b1);
  endtask

  task automatic async_rst_check();
    #3;
    RST_I = 1'b0;
    #1;
    checks++;
    if (IS_ALWAYS_1_O != '0 || IS_ALWAYS_0_O != '0) begin
      errors++;
      $display("FAIL async_reset got one=%b zero=%b want 00/00",
               IS_ALWAYS_1_O, IS_ALWAYS_0_O);
    end
    for (int i = 0; i < W; i++) run[i] = 0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK_I);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (IS_ALWAYS_1_O != e.one || IS_ALWAYS_0_O != e.zero) begin
          errors++;
          $display("FAIL flags t=%0t got one=%b zero=%b want one=%b zero=%b",
                   $time, IS_ALWAYS_1_O, IS_ALWAYS_0_O, e.one, e.zero);
        end
        checks++;
        if ((IS_ALWAYS_1_O & IS_ALWAYS_0_O) != '0) begin
          errors++;
          $display("FAIL exclusive got one=%b zero=%b want disjoint",
                   IS_ALWAYS_1_O, IS_ALWAYS_0_O);
        end
      end
    end
  end

  initial begin : stim
    logic [W-1:0] d;
    int           n;
    for (int i = 0; i < W; i++) run[i] = 0;

    for (int k = 0; k < 50; k++) step(2'b00, 1'b0);
    hold(2'b00, 40);
    hold(2'b01, 38);
    hold(2'b00, 20);
    hold(2'b11, 50);
    hold(2'b10, 31);
    hold(2'b11, 1000);
    async_rst_check();
    step(2'b11, 1'b0);
    hold(2'b11, 40);
    hold(2'b00, TH - 1);
    hold(2'b11, TH);

    for (int r = 0; r < 70; r++) begin
      d = W'($urandom);
      case ($urandom_range(0, 3))
        0: n = $urandom_range(1, 8);
        1: n = $urandom_range(TH - 2, TH + 2);
        2: n = $urandom_range(1, 60);
        default: n = $urandom_range(TH + 3, 3 * TH);
      endcase
      hold(d, n);
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) begin
          async_rst_check();
          step(d, 1'b0);
        end else begin
          step(d, 1'b0);
          step(d, 1'b0);
        end
      end
    end

    repeat (3) @(posedge CLK_I);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
